trig_latency_meas: RTL and testbench

- Measures the clk-cycle latency between a trigger edge (start_in) and its response edge (stop_in), e.g. a delayed trigger output or a camera strobe feedback.
- This is the measuring counterpart of the trigger delay path: it recovers the delay from two observed edges instead of generating it.
- Sits in trigger_process next to the delay blocks.
- Results and statistics go to the register bank for calibration and debug.

---
 rtl/trig_latency_meas.sv | 163 ++++++++++++++++
 tb/tb_trig_latency_meas.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_latency_meas.sv
// Trigger-to-response latency meter: counts clk cycles between a qualified
// start edge and a qualified stop edge, with timeout and min/max/count stats.
module trig_latency_meas #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [CNT_W-1:0]  timeout_value,
  input  logic              start_in,
  input  logic              stop_in,
  output logic              meas_busy,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  meas_value,
  output logic              meas_timeout,
  output logic [CNT_W-1:0]  max_value,
  output logic [CNT_W-1:0]  min_value,
  output logic [STAT_W-1:0] meas_cnt,
  output logic [STAT_W-1:0] timeout_cnt
);

  localparam int unsigned HIST_W = 4;
  localparam logic [HIST_W-1:0] EDGE_PAT = 4'b0001;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [HIST_W-1:0] start_hist_q, stop_hist_q;
  logic              start_r, stop_r;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tmo_lock_q, tmo_lock_d;
  logic [CNT_W-1:0]  value_q, value_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;

  logic [CNT_W-1:0]  max_q, max_d;
  logic [CNT_W-1:0]  min_q, min_d;
  logic [STAT_W-1:0] mcnt_q, mcnt_d;
  logic [STAT_W-1:0] tcnt_q, tcnt_d;

  // Identical 4-deep histories keep both edge paths at the same latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_hist_q <= '0;
      stop_hist_q  <= '0;
    end else begin
      start_hist_q <= {start_hist_q[HIST_W-2:0], start_in};
      stop_hist_q  <= {stop_hist_q[HIST_W-2:0], stop_in};
    end
  end

  assign start_r = (start_hist_q == EDGE_PAT);
  assign stop_r  = (stop_hist_q == EDGE_PAT);

  // State and measurement registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tmo_lock_q <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_lock_q <= tmo_lock_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: stop beats timeout, start beats a simultaneous stop in IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_lock_d = tmo_lock_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_r) begin
          state_d    = MEASURE;
          cnt_d      = CNT_W'(1);
          tmo_lock_d = timeout_value;
        end
      end
      MEASURE: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (stop_r) begin
          value_d = cnt_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (((tmo_lock_q != '0) && (cnt_q == tmo_lock_q)) ||
                     (cnt_q == CNT_MAX)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MEASURE);
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q  <= '0;
      min_q  <= '1;
      mcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      max_q  <= max_d;
      min_q  <= min_d;
      mcnt_q <= mcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  // Stats follow the registered result pulses; clear drops a coincident result.
  always_comb begin
    max_d  = max_q;
    min_d  = min_q;
    mcnt_d = mcnt_q;
    tcnt_d = tcnt_q;
    if (clear) begin
      max_d  = '0;
      min_d  = '1;
      mcnt_d = '0;
      tcnt_d = '0;
    end else begin
      if (valid_q) begin
        if (value_q > max_q) max_d = value_q;
        if (value_q < min_q) min_d = value_q;
        if (mcnt_q != STAT_MAX) mcnt_d = mcnt_q + STAT_W'(1);
      end
      if (timeout_q && (tcnt_q != STAT_MAX)) tcnt_d = tcnt_q + STAT_W'(1);
    end
  end

  assign meas_busy    = busy_q;
  assign meas_valid   = valid_q;
  assign meas_value   = value_q;
  assign meas_timeout = timeout_q;
  assign max_value    = max_q;
  assign min_value    = min_q;
  assign meas_cnt     = mcnt_q;
  assign timeout_cnt  = tcnt_q;

endmodule

// File: tb/tb_trig_latency_meas.sv
// Bench for trig_latency_meas: scenario tasks checked against an edge-distance
// model of the latency meter and its statistics.
module tb_trig_latency_meas;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [31:0] timeout_value;
  logic        start_in;
  logic        stop_in;
  logic        meas_busy;
  logic        meas_valid;
  logic [31:0] meas_value;
  logic        meas_timeout;
  logic [31:0] max_value;
  logic [31:0] min_value;
  logic [15:0] meas_cnt;
  logic [15:0] timeout_cnt;

  trig_latency_meas #(.CNT_W(32), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .timeout_value(timeout_value),
    .start_in(start_in), .stop_in(stop_in), .meas_busy(meas_busy),
    .meas_valid(meas_valid), .meas_value(meas_value), .meas_timeout(meas_timeout),
    .max_value(max_value), .min_value(min_value), .meas_cnt(meas_cnt),
    .timeout_cnt(timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;
  int nv, nt, nbusy, rel_valid, rel_tmo;

  // Model state: last result and statistics since clear.
  logic [31:0] exp_value, exp_min, exp_max;
  logic [15:0] exp_cnt, exp_tcnt;

  task automatic model_clear();
    exp_min = 32'hFFFF_FFFF; exp_max = 32'd0; exp_cnt = 16'd0; exp_tcnt = 16'd0;
  endtask

  // kind: 1 = valid result, 2 = timeout, 0 = nothing. lat counts cycles from
  // the start_in rise to the visible pulse (two history samples + one result).
  function automatic void predict(input int d, input int t, output int kind,
                                  output int val, output int lat);
    kind = 0; val = 0; lat = -1;
    if (d >= 1 && (t == 0 || d <= t)) begin
      kind = 1; val = d; lat = d + 2;
    end else if (t != 0) begin
      kind = 2; lat = t + 2;
    end
  endfunction

  task automatic model_apply(input int kind, input int val);
    if (kind == 1) begin
      exp_value = 32'(val);
      if (32'(val) > exp_max) exp_max = 32'(val);
      if (32'(val) < exp_min) exp_min = 32'(val);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end else if (kind == 2) begin
      if (exp_tcnt != 16'hFFFF) exp_tcnt = exp_tcnt + 16'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (meas_valid) begin nv++; rel_valid = cyc - base; end
    if (meas_timeout) begin nt++; rel_tmo = cyc - base; end
    if (meas_busy) nbusy++;
  endtask

  task automatic clr_counts();
    nv = 0; nt = 0; nbusy = 0; rel_valid = -1; rel_tmo = -1;
  endtask

  // start_in rises now; stop_in rises d cycles later (d<0: never).
  task automatic run_pair(input int d, input logic [31:0] t, input int budget,
                          input int chg_at, input int restart_at, input bit clr_on_valid);
    clr_counts();
    timeout_value = t;
    start_in = 1'b1;
    if (d == 0) stop_in = 1'b1;
    base = cyc;
    for (int i = 1; i <= budget; i++) begin
      step();
      clear = 1'b0;
      if (clr_on_valid && meas_valid) clear = 1'b1;
      if (i == d) stop_in = 1'b1;
      if (i == chg_at) timeout_value = 32'd1000;
      if (restart_at > 0 && i == restart_at) start_in = 1'b0;
      if (restart_at > 0 && i == restart_at + 5) start_in = 1'b1;
    end
    start_in = 1'b0; stop_in = 1'b0; clear = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; start_in = 1'b0; stop_in = 1'b0; timeout_value = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();
    exp_value = 32'd0; model_clear();
    tests++; if (meas_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", meas_busy); end
    tests++; if (meas_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", meas_valid); end
    tests++; if (meas_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", meas_timeout); end
    tests++; if (meas_value !== 32'd0) begin fails++; $display("FAIL reset_value got %0d want 0", meas_value); end
    tests++; if (max_value !== 32'd0) begin fails++; $display("FAIL reset_max got %0d want 0", max_value); end
    tests++; if (min_value !== 32'hFFFF_FFFF) begin fails++; $display("FAIL reset_min got %h want ffffffff", min_value); end
    tests++; if (meas_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", meas_cnt, timeout_cnt); end
  endtask

  task automatic test_delay100();
    int kind, val, lat;
    predict(100, 0, kind, val, lat);
    run_pair(100, 32'd0, 105, 0, 0, 1'b0);
    model_apply(kind, val);
    tests++; if (nv !== 1 || nt !== 0) begin fails++; $display("FAIL d100_pulses got v%0d t%0d want v1 t0", nv, nt); end
    tests++; if (rel_valid !== lat) begin fails++; $display("FAIL d100_latency got %0d want %0d", rel_valid, lat); end
    tests++; if (meas_value !== exp_value) begin fails++; $display("FAIL d100_value got %0d want %0d", meas_value, exp_value); end
    tests++; if (meas_cnt !== exp_cnt || min_value !== exp_min || max_value !== exp_max) begin
      fails++; $display("FAIL d100_stats got cnt%0d min%0d max%0d want cnt%0d min%0d max%0d",
                        meas_cnt, min_value, max_value, exp_cnt, exp_min, exp_max); end
  endtask

  task automatic test_sequence();
    int kind, val, lat, d, t, sel;
    int dl[3] = '{50, 200, 75};
    clear = 1'b1; step(); clear = 1'b0; step();
    model_clear();
    for (int k = 0; k < 3; k++) begin
      predict(dl[k], 0, kind, val, lat);
      run_pair(dl[k], 32'd0, dl[k] + 4, 0, 0, 1'b0);
      model_apply(kind, val);
    end
    tests++; if (meas_cnt !== 16'd3 || min_value !== 32'd50 || max_value !== 32'd200 || meas_value !== 32'd75) begin
      fails++; $display("FAIL seq_stats got cnt%0d min%0d max%0d val%0d want 3/50/200/75",
                        meas_cnt, min_value, max_value, meas_value); end
    for (int k = 0; k < 10; k++) begin
      d = int'($urandom_range(1, 150));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: t = 0;
        1: t = d;
        2: t = (d > 1) ? d - 1 : d;
        default: t = int'($urandom_range(1, 150));
      endcase
      predict(d, t, kind, val, lat);
      run_pair(d, 32'(t), ((d > t) ? d : t) + 4, 0, 0, 1'b0);
      model_apply(kind, val);
      tests++;
      if (nv !== (kind == 1 ? 1 : 0) || nt !== (kind == 2 ? 1 : 0) ||
          (kind == 1 && rel_valid !== lat) || (kind == 2 && rel_tmo !== lat)) begin
        fails++; $display("FAIL rand_pulse d%0d t%0d got v%0d@%0d t%0d@%0d want kind%0d@%0d",
                          d, t, nv, rel_valid, nt, rel_tmo, kind, lat); end
      tests++;
      if (meas_value !== exp_value || meas_cnt !== exp_cnt || timeout_cnt !== exp_tcnt ||
          min_value !== exp_min || max_value !== exp_max) begin
        fails++; $display("FAIL rand_stats d%0d t%0d got v%0d c%0d tc%0d mn%0d mx%0d want v%0d c%0d tc%0d mn%0d mx%0d",
                          d, t, meas_value, meas_cnt, timeout_cnt, min_value, max_value,
                          exp_value, exp_cnt, exp_tcnt, exp_min, exp_max); end
    end
  endtask

  task automatic test_timeout();
    int kind, val, lat;
    predict(-1, 40, kind, val, lat);
    run_pair(-1, 32'd40, 46, 10, 0, 1'b0);
    model_apply(kind, val);
    tests++; if (nt !== 1 || nv !== 0) begin fails++; $display("FAIL tmo_pulses got v%0d t%0d want v0 t1", nv, nt); end
    tests++; if (rel_tmo !== lat) begin fails++; $display("FAIL tmo_latency got %0d want %0d", rel_tmo, lat); end
    tests++; if (meas_value !== exp_value) begin fails++; $display("FAIL tmo_value got %0d want %0d", meas_value, exp_value); end
    tests++; if (timeout_cnt !== exp_tcnt) begin fails++; $display("FAIL tmo_count got %0d want %0d", timeout_cnt, exp_tcnt); end
  endtask

  task automatic test_same_edge_restart();
    int kind, val, lat;
    predict(0, 10, kind, val, lat);
    run_pair(0, 32'd10, 16, 0, 0, 1'b0);
    model_apply(kind, val);
    tests++; if (nv !== 0 || nt !== 1 || rel_tmo !== lat) begin
      fails++; $display("FAIL same_edge got v%0d t%0d@%0d want v0 t1@%0d", nv, nt, rel_tmo, lat); end
    predict(30, 0, kind, val, lat);
    run_pair(30, 32'd0, 34, 0, 5, 1'b0);
    model_apply(kind, val);
    tests++; if (nv !== 1 || rel_valid !== lat || meas_value !== 32'd30) begin
      fails++; $display("FAIL restart got v%0d@%0d val%0d want v1@%0d val30", nv, rel_valid, meas_value, lat); end
  endtask

  task automatic test_filter();
    clr_counts();
    timeout_value = 32'd5;
    start_in = 1'b1;
    base = cyc;
    for (int i = 1; i <= 45; i++) begin
      step();
      if (i == 20) start_in = 1'b0;
      if (i == 21) begin start_in = 1'b1; nbusy = 0; end
    end
    model_apply(2, 0);
    tests++; if (nt !== 1 || nbusy !== 0) begin fails++; $display("FAIL glitch_filter got t%0d busy%0d want t1 busy0", nt, nbusy); end
    start_in = 1'b0;
    repeat (5) step();
    clr_counts();
    stop_in = 1'b1; step(); stop_in = 1'b0;
    repeat (10) step();
    tests++; if (nv !== 0 || nt !== 0 || nbusy !== 0) begin
      fails++; $display("FAIL idle_stop got v%0d t%0d busy%0d want 0/0/0", nv, nt, nbusy); end
    tests++; if (timeout_cnt !== exp_tcnt || meas_value !== exp_value) begin
      fails++; $display("FAIL filter_stats got tc%0d v%0d want tc%0d v%0d", timeout_cnt, meas_value, exp_tcnt, exp_value); end
  endtask

  task automatic test_clear_on_result();
    run_pair(20, 32'd0, 24, 0, 0, 1'b1);
    exp_value = 32'd20;
    model_clear();
    tests++; if (nv !== 1 || meas_value !== exp_value) begin fails++; $display("FAIL clr_value got v%0d val%0d want v1 val20", nv, meas_value); end
    tests++; if (meas_cnt !== 16'd0 || timeout_cnt !== 16'd0 || min_value !== exp_min || max_value !== exp_max) begin
      fails++; $display("FAIL clr_stats got c%0d tc%0d mn%h mx%0d want 0/0/ffffffff/0", meas_cnt, timeout_cnt, min_value, max_value); end
  endtask

  task automatic test_rst_mid();
    int kind, val, lat;
    clr_counts();
    timeout_value = 32'd0;
    start_in = 1'b1;
    base = cyc;
    repeat (10) step();
    rst = 1'b1; start_in = 1'b0;
    #1;
    exp_value = 32'd0; model_clear();
    tests++; if (meas_busy !== 1'b0 || meas_value !== 32'd0 || meas_valid !== 1'b0 || meas_timeout !== 1'b0) begin
      fails++; $display("FAIL rst_mid_outputs got b%b v%b t%b val%0d want 0/0/0/0", meas_busy, meas_valid, meas_timeout, meas_value); end
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    tests++; if (nv !== 0 || nt !== 0) begin fails++; $display("FAIL rst_mid_pulses got v%0d t%0d want 0/0", nv, nt); end
    predict(25, 0, kind, val, lat);
    run_pair(25, 32'd0, 29, 0, 0, 1'b0);
    model_apply(kind, val);
    tests++; if (meas_value !== exp_value || rel_valid !== lat || meas_cnt !== exp_cnt ||
                 min_value !== exp_min || max_value !== exp_max) begin
      fails++; $display("FAIL rst_mid_after got val%0d@%0d c%0d mn%0d mx%0d want val%0d@%0d c%0d mn%0d mx%0d",
                        meas_value, rel_valid, meas_cnt, min_value, max_value,
                        exp_value, lat, exp_cnt, exp_min, exp_max); end
  endtask

  initial begin
    test_reset();
    test_delay100();
    test_sequence();
    test_timeout();
    test_same_edge_restart();
    test_filter();
    test_clear_on_result();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
